// File: rtl/vga_mon_pkg.sv
// Shared types and constants for the VGA timing monitor: lock FSM states,
// nominal 640x480@60 timing and the CRC-16-CCITT step used by the optional frame CRC.
package vga_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_CW       = 11;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One whole 24-bit pixel folded into the CRC in a single combinational step, MSB first.
    function automatic logic [15:0] crc16_step24(input logic [15:0] crc, input logic [23:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync polarity normalisation and assertion-edge detect, sampled on pixel-enable cycles.
// assert_edge is combinational from the current sample; the caller qualifies it with pix_en.
module vga_sync_edge
    import vga_mon_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sync_in,
    output logic assert_edge
);

    logic sync_a;
    logic sync_prev;

    assign sync_a      = sync_in ^ ACTIVE_LOW;
    assign assert_edge = sync_a & ~sync_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_prev <= 1'b0;
        end else if (pix_en) begin
            sync_prev <= sync_a;
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// Receiver-side VGA timing checker: recovers active-pixel coordinates, measures line/frame
// lengths and runs a lock FSM against nominal timing. Define VGA_MON_CRC_EN for a per-frame CRC.
module vga_timing_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL         = DEF_H_TOTAL,
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int V_TOTAL         = DEF_V_TOTAL,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int CW              = DEF_CW
) (
    input  logic          clock50,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          vga_hs,
    input  logic          vga_vs,
    input  logic          vga_blank_n,
    input  logic [23:0]   vga_rgb,
    output logic [9:0]    pix_x,
    output logic [9:0]    pix_y,
    output logic          pix_valid,
    output logic [23:0]   pix_rgb,
    output logic          frame_start,
    output logic [CW-1:0] h_total_meas,
    output logic [CW-1:0] v_total_meas,
    output logic          locked,
    output logic [7:0]    err_cnt,
`ifdef VGA_MON_CRC_EN
    output logic [15:0]   frame_crc,
    output logic          frame_crc_valid,
`endif
    output mon_state_t    dbg_state
);

    // pix_valid is a one-cycle qualifier for pix_x/pix_y/pix_rgb with no ready path:
    // the consumer must take the beat in the cycle it is presented.

    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
    localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] X_LAST_C   = CW'(H_ACTIVE - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    mon_state_t    state, state_next;
    logic          err_inc;
    logic          hs_edge_raw, vs_edge_raw;
    logic          hs_edge, vs_edge;
    logic          blank_prev, blank_rise, blank_fall;
    logic [CW-1:0] h_cnt, v_cnt, x_cnt, y_cnt;
    logic [CW-1:0] h_meas_new, y_total;
    logic          frame_err, line_bad, frame_ok, too_long;

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_edge (
        .clk         (clock50),
        .reset       (reset),
        .pix_en      (pix_en),
        .sync_in     (vga_hs),
        .assert_edge (hs_edge_raw)
    );

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_edge (
        .clk         (clock50),
        .reset       (reset),
        .pix_en      (pix_en),
        .sync_in     (vga_vs),
        .assert_edge (vs_edge_raw)
    );

    assign hs_edge    = pix_en & hs_edge_raw;
    assign vs_edge    = pix_en & vs_edge_raw;
    assign blank_rise = pix_en & vga_blank_n & ~blank_prev;
    assign blank_fall = pix_en & ~vga_blank_n & blank_prev;

    // A line or active run closing on this very sample still belongs to the frame being judged.
    assign h_meas_new = sat_inc(h_cnt);
    assign line_bad   = (hs_edge && (h_meas_new != H_TOTAL_C)) ||
                        (blank_fall && (x_cnt != X_LAST_C));
    assign y_total    = blank_fall ? sat_inc(y_cnt) : y_cnt;
    assign frame_ok   = !frame_err && !line_bad &&
                        (v_cnt == V_TOTAL_C) && (y_total == V_ACTIVE_C);
    // Another line start with the full line budget already used means VS went missing.
    assign too_long   = hs_edge && !vs_edge && (v_cnt >= V_TOTAL_C);

    always_comb begin
        state_next = state;
        err_inc    = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_edge) state_next = MEASURE;
            end
            MEASURE: begin
                if (vs_edge && frame_ok) state_next = LOCKED;
            end
            LOCKED: begin
                if (line_bad || too_long || (vs_edge && !frame_ok)) begin
                    state_next = MEASURE;
                    err_inc    = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            state        <= SEARCH;
            locked       <= 1'b0;
            err_cnt      <= 8'd0;
            pix_valid    <= 1'b0;
            frame_start  <= 1'b0;
            pix_rgb      <= 24'd0;
            blank_prev   <= 1'b0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            frame_err    <= 1'b0;
        end else begin
            state       <= state_next;
            locked      <= (state_next == LOCKED);
            pix_valid   <= pix_en & vga_blank_n;
            frame_start <= vs_edge;
            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

            if (pix_en) begin
                pix_rgb    <= vga_rgb;
                blank_prev <= vga_blank_n;

                if (hs_edge) begin
                    h_cnt        <= '0;
                    h_total_meas <= h_meas_new;
                end else begin
                    h_cnt <= sat_inc(h_cnt);
                end

                // VS first; a coincident HS then counts as the first line of the new frame.
                if (vs_edge) begin
                    v_total_meas <= v_cnt;
                    v_cnt        <= hs_edge ? CW'(1) : '0;
                end else if (hs_edge) begin
                    v_cnt <= sat_inc(v_cnt);
                end

                if (blank_rise) begin
                    x_cnt <= '0;
                end else if (vga_blank_n) begin
                    x_cnt <= sat_inc(x_cnt);
                end

                if (vs_edge) begin
                    y_cnt <= '0;
                end else if (blank_fall) begin
                    y_cnt <= sat_inc(y_cnt);
                end

                if (vs_edge) begin
                    frame_err <= 1'b0;
                end else if (line_bad) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign pix_x     = x_cnt[9:0];
    assign pix_y     = y_cnt[9:0];
    assign dbg_state = state;

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc_acc;

    // Accumulator starts from the CRC seed so the first whole frame after reset is correct.
    always_ff @(posedge clock50) begin
        if (reset) begin
            crc_acc         <= CRC_INIT;
            frame_crc       <= 16'd0;
            frame_crc_valid <= 1'b0;
        end else begin
            frame_crc_valid <= 1'b0;
            if (frame_start) begin
                frame_crc       <= crc_acc;
                frame_crc_valid <= 1'b1;
                crc_acc         <= pix_valid ? crc16_step24(CRC_INIT, pix_rgb) : CRC_INIT;
            end else if (pix_valid) begin
                crc_acc <= crc16_step24(crc_acc, pix_rgb);
            end
        end
    end
`endif

endmodule
